l1_l2_arbiter: RTL and testbench

L1_L2_ARBITER -- requirements
Module: l1_l2_arbiter

---
 rtl/l1_l2_arbiter.sv | 126 ++++++++++++
 tb/tb_l1_l2_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter: shares a single L2 port between the L1I refill path and the
// L1D refill/writeback paths. One transaction is outstanding at a time; the
// winner's address (and writeback data) is captured at grant, and the L2 side
// is driven only from those registers until L2 signals completion.
//
// state | meaning
// IDLE  | no grant; arbitrate when flush is low
// G_I   | L1I refill in flight
// G_DR  | L1D refill in flight
// G_DW  | L1D writeback in flight
module l1_l2_arbiter (
    input  logic         clk,
    input  logic         nrst,
    input  logic         read_L1I_L2,
    input  logic [20:0]  tag_L1I_L2,
    input  logic [4:0]   index_L1I_L2,
    input  logic         read_L1D_L2,
    input  logic [20:0]  tag_L1D_L2,
    input  logic [4:0]   index_L1D_L2,
    input  logic         write_L1D_L2,
    input  logic [20:0]  write_tag_L1D_L2,
    input  logic [4:0]   write_index_L1D_L2,
    input  logic [511:0] write_data_L1D_L2,
    input  logic         flush,
    input  logic         ready_L2_L1,
    output logic         read_L1_L2,
    output logic         write_L1_L2,
    output logic [20:0]  tag_L1_L2,
    output logic [4:0]   index_L1_L2,
    output logic [511:0] write_data_L1_L2,
    output logic         ready_L2_L1I,
    output logic         ready_L2_L1D,
    output logic         busy,
    output logic [1:0]   grant_o
);

    // Encodings chosen to equal grant_o so the state can be reported directly.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G_I  = 2'b01,
        G_DR = 2'b10,
        G_DW = 2'b11
    } state_t;

    state_t         state_q, state_d;
    logic           rr_q, rr_d;        // 0: favour L1I, 1: favour L1D
    logic [20:0]    tag_q, tag_d;
    logic [4:0]     index_q, index_d;
    logic [511:0]   wdata_q, wdata_d;

    // Arbitration, address capture and completion handling.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        tag_d   = tag_q;
        index_d = index_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (!flush) begin
                    if (write_L1D_L2) begin
                        state_d = G_DW;
                        tag_d   = write_tag_L1D_L2;
                        index_d = write_index_L1D_L2;
                        wdata_d = write_data_L1D_L2;
                    end else if (read_L1D_L2 && (!read_L1I_L2 || rr_q)) begin
                        state_d = G_DR;
                        tag_d   = tag_L1D_L2;
                        index_d = index_L1D_L2;
                    end else if (read_L1I_L2) begin
                        state_d = G_I;
                        tag_d   = tag_L1I_L2;
                        index_d = index_L1I_L2;
                    end
                end
            end
            G_I: begin
                if (ready_L2_L1) begin
                    state_d = IDLE;
                    rr_d    = 1'b1;
                end
            end
            G_DR: begin
                if (ready_L2_L1) begin
                    state_d = IDLE;
                    rr_d    = 1'b0;
                end
            end
            G_DW: begin
                // Writebacks do not move the read round-robin pointer.
                if (ready_L2_L1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer and captured request registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            tag_q   <= '0;
            index_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            tag_q   <= tag_d;
            index_q <= index_d;
            wdata_q <= wdata_d;
        end
    end

    assign read_L1_L2       = (state_q == G_I) || (state_q == G_DR);
    assign write_L1_L2      = (state_q == G_DW);
    assign tag_L1_L2        = tag_q;
    assign index_L1_L2      = index_q;
    assign write_data_L1_L2 = wdata_q;
    assign ready_L2_L1I     = ready_L2_L1 && (state_q == G_I);
    assign ready_L2_L1D     = ready_L2_L1 && ((state_q == G_DR) || (state_q == G_DW));
    assign busy             = (state_q != IDLE);
    assign grant_o          = state_q;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Bench for l1_l2_arbiter: expected grants are queued as requests are driven
// and matched against each new grant the DUT issues; tasks also check timing,
// address hold, flush and reset behaviour inline.
module tb_l1_l2_arbiter;

    logic         clk;
    logic         nrst;
    logic         read_L1I_L2;
    logic [20:0]  tag_L1I_L2;
    logic [4:0]   index_L1I_L2;
    logic         read_L1D_L2;
    logic [20:0]  tag_L1D_L2;
    logic [4:0]   index_L1D_L2;
    logic         write_L1D_L2;
    logic [20:0]  write_tag_L1D_L2;
    logic [4:0]   write_index_L1D_L2;
    logic [511:0] write_data_L1D_L2;
    logic         flush;
    logic         ready_L2_L1;
    logic         read_L1_L2;
    logic         write_L1_L2;
    logic [20:0]  tag_L1_L2;
    logic [4:0]   index_L1_L2;
    logic [511:0] write_data_L1_L2;
    logic         ready_L2_L1I;
    logic         ready_L2_L1D;
    logic         busy;
    logic [1:0]   grant_o;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [1:0]   g;
        logic [20:0]  tag;
        logic [4:0]   idx;
        logic [511:0] data;
    } exp_t;

    exp_t         sb[$];
    exp_t         e;
    logic         prev_busy = 1'b0;
    logic [511:0] last_wdata = '0;

    l1_l2_arbiter dut (
        .clk                (clk),
        .nrst               (nrst),
        .read_L1I_L2        (read_L1I_L2),
        .tag_L1I_L2         (tag_L1I_L2),
        .index_L1I_L2       (index_L1I_L2),
        .read_L1D_L2        (read_L1D_L2),
        .tag_L1D_L2         (tag_L1D_L2),
        .index_L1D_L2       (index_L1D_L2),
        .write_L1D_L2       (write_L1D_L2),
        .write_tag_L1D_L2   (write_tag_L1D_L2),
        .write_index_L1D_L2 (write_index_L1D_L2),
        .write_data_L1D_L2  (write_data_L1D_L2),
        .flush              (flush),
        .ready_L2_L1        (ready_L2_L1),
        .read_L1_L2         (read_L1_L2),
        .write_L1_L2        (write_L1_L2),
        .tag_L1_L2          (tag_L1_L2),
        .index_L1_L2        (index_L1_L2),
        .write_data_L1_L2   (write_data_L1_L2),
        .ready_L2_L1I       (ready_L2_L1I),
        .ready_L2_L1D       (ready_L2_L1D),
        .busy               (busy),
        .grant_o            (grant_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every new grant must match the oldest queued expectation.
    always @(negedge clk) begin
        if (busy && !prev_busy) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fails++;
                $display("FAIL unexpected_grant: grant_o=%b with nothing expected", grant_o);
            end else begin
                e = sb.pop_front();
                if ({grant_o, tag_L1_L2, index_L1_L2} !== {e.g, e.tag, e.idx} ||
                    write_data_L1_L2 !== e.data) begin
                    n_fails++;
                    $display("FAIL grant_match: got g=%b tag=%h idx=%h data_ok=%0d, expected g=%b tag=%h idx=%h",
                             grant_o, tag_L1_L2, index_L1_L2, (write_data_L1_L2 === e.data),
                             e.g, e.tag, e.idx);
                end
            end
        end
        prev_busy = busy;
    end

    task automatic push_exp(input logic [1:0] g, input logic [20:0] tag,
                            input logic [4:0] idx, input logic [511:0] data);
        exp_t x;
        x.g = g; x.tag = tag; x.idx = idx; x.data = data;
        sb.push_back(x);
    endtask

    // Called at a negedge; returns at the first negedge with busy high.
    task automatic wait_busy(input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Completes the current grant after 'delay' cycles; returns at the
    // turnaround negedge with the routed ready values that were observed.
    task automatic finish_txn(input int delay, output logic ri, output logic rd);
        repeat (delay) @(negedge clk);
        ready_L2_L1 = 1'b1;
        #1;
        ri = ready_L2_L1I;
        rd = ready_L2_L1D;
        @(negedge clk);
        ready_L2_L1 = 1'b0;
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        #3;
        n_checks++;
        if ({busy, grant_o, read_L1_L2, write_L1_L2, ready_L2_L1I, ready_L2_L1D} !== 7'b0 ||
            tag_L1_L2 !== 21'h0 || index_L1_L2 !== 5'h0 || write_data_L1_L2 !== 512'h0) begin
            n_fails++;
            $display("FAIL reset_values: busy=%b grant=%b rd=%b wr=%b tag=%h idx=%h",
                     busy, grant_o, read_L1_L2, write_L1_L2, tag_L1_L2, index_L1_L2);
        end
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_all_three;
        bit ok;
        logic ri, rd;
        logic [511:0] wd;
        wd = {16{32'hC0FFEE01}};
        push_exp(2'b11, 21'h0AAAA, 5'h11, wd);
        push_exp(2'b01, 21'h01111, 5'h01, wd);
        push_exp(2'b10, 21'h02222, 5'h02, wd);
        last_wdata = wd;
        write_L1D_L2 = 1'b1; write_tag_L1D_L2 = 21'h0AAAA; write_index_L1D_L2 = 5'h11;
        write_data_L1D_L2 = wd;
        read_L1I_L2 = 1'b1; tag_L1I_L2 = 21'h01111; index_L1I_L2 = 5'h01;
        read_L1D_L2 = 1'b1; tag_L1D_L2 = 21'h02222; index_L1D_L2 = 5'h02;
        wait_busy(20, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL all3_first_grant: timed out"); end
        write_L1D_L2 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            finish_txn(1, ri, rd);
            n_checks++;
            if (busy !== 1'b0) begin
                n_fails++;
                $display("FAIL all3_turnaround%0d: busy=%b expected 0", k, busy);
            end
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b1) begin
                n_fails++;
                $display("FAIL all3_regrant%0d: busy=%b expected 1", k, busy);
            end
            if (k == 0) read_L1I_L2 = 1'b0;
            else        read_L1D_L2 = 1'b0;
        end
        finish_txn(1, ri, rd);
        n_checks++;
        if ({ri, rd} !== 2'b01) begin
            n_fails++;
            $display("FAIL all3_last_ready: ri=%b rd=%b expected 0 1", ri, rd);
        end
    endtask

    // Pointer favours L1I here (last completion was an L1D read).
    task automatic test_round_robin;
        bit ok;
        logic ri, rd;
        for (int k = 0; k < 4; k++)
            push_exp((k % 2 == 0) ? 2'b01 : 2'b10, (k % 2 == 0) ? 21'h03333 : 21'h04444,
                     (k % 2 == 0) ? 5'h03 : 5'h04, last_wdata);
        read_L1I_L2 = 1'b1; tag_L1I_L2 = 21'h03333; index_L1I_L2 = 5'h03;
        read_L1D_L2 = 1'b1; tag_L1D_L2 = 21'h04444; index_L1D_L2 = 5'h04;
        for (int k = 0; k < 4; k++) begin
            wait_busy(20, ok);
            n_checks++;
            if (!ok) begin n_fails++; $display("FAIL rr_grant%0d: timed out", k); end
            finish_txn(0, ri, rd);
            n_checks++;
            if ({ri, rd} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fails++;
                $display("FAIL rr_ready%0d: ri=%b rd=%b", k, ri, rd);
            end
        end
        read_L1I_L2 = 1'b0;
        read_L1D_L2 = 1'b0;
    endtask

    task automatic test_single_l1i;
        bit ok;
        push_exp(2'b01, 21'h1ABCD, 5'h05, last_wdata);
        read_L1I_L2 = 1'b1; tag_L1I_L2 = 21'h1ABCD; index_L1I_L2 = 5'h05;
        @(negedge clk);
        wait_busy(2, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL single_grant: no grant one cycle after request"); end
        read_L1I_L2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({read_L1_L2, write_L1_L2, ready_L2_L1I, ready_L2_L1D} !== 4'b1000 ||
                tag_L1_L2 !== 21'h1ABCD || index_L1_L2 !== 5'h05) begin
                n_fails++;
                $display("FAIL single_hold%0d: rd=%b wr=%b tag=%h idx=%h", k, read_L1_L2,
                         write_L1_L2, tag_L1_L2, index_L1_L2);
            end
            @(negedge clk);
        end
        ready_L2_L1 = 1'b1;
        #1;
        n_checks++;
        if ({read_L1_L2, ready_L2_L1I, ready_L2_L1D} !== 3'b110) begin
            n_fails++;
            $display("FAIL single_ready: rd=%b ri=%b rdD=%b expected 1 1 0",
                     read_L1_L2, ready_L2_L1I, ready_L2_L1D);
        end
        @(negedge clk);
        ready_L2_L1 = 1'b0;
        n_checks++;
        if ({busy, read_L1_L2} !== 2'b00) begin
            n_fails++;
            $display("FAIL single_release: busy=%b rd=%b expected 0 0", busy, read_L1_L2);
        end
    endtask

    task automatic test_addr_hold;
        bit ok;
        logic ri, rd;
        push_exp(2'b01, 21'h00001, 5'h03, last_wdata);
        read_L1I_L2 = 1'b1; tag_L1I_L2 = 21'h00001; index_L1I_L2 = 5'h03;
        wait_busy(20, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL hold_grant: timed out"); end
        tag_L1I_L2 = 21'h00002;
        index_L1I_L2 = 5'h1F;
        read_L1I_L2 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (tag_L1_L2 !== 21'h00001 || index_L1_L2 !== 5'h03 || busy !== 1'b1) begin
                n_fails++;
                $display("FAIL hold_addr: tag=%h idx=%h busy=%b expected 00001 03 1",
                         tag_L1_L2, index_L1_L2, busy);
            end
        end
        finish_txn(0, ri, rd);
        n_checks++;
        if ({ri, rd} !== 2'b10 || tag_L1_L2 !== 21'h00001 || read_L1_L2 !== 1'b0) begin
            n_fails++;
            $display("FAIL hold_idle: ri=%b rd=%b tag=%h strobe=%b", ri, rd, tag_L1_L2, read_L1_L2);
        end
    endtask

    task automatic test_flush;
        bit ok;
        logic ri, rd;
        logic [511:0] wd;
        flush = 1'b1;
        read_L1D_L2 = 1'b1; tag_L1D_L2 = 21'h05555; index_L1D_L2 = 5'h15;
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0) begin
                n_fails++;
                $display("FAIL flush_block: busy=%b expected 0", busy);
            end
        end
        push_exp(2'b10, 21'h05555, 5'h15, last_wdata);
        flush = 1'b0;
        wait_busy(20, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL flush_release_grant: timed out"); end
        read_L1D_L2 = 1'b0;
        finish_txn(0, ri, rd);
        wd = {8{64'h0123456789ABCDEF}};
        push_exp(2'b11, 21'h17777, 5'h07, wd);
        last_wdata = wd;
        write_L1D_L2 = 1'b1; write_tag_L1D_L2 = 21'h17777; write_index_L1D_L2 = 5'h07;
        write_data_L1D_L2 = wd;
        wait_busy(20, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL flush_dw_grant: timed out"); end
        write_L1D_L2 = 1'b0;
        flush = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if ({busy, write_L1_L2, read_L1_L2} !== 3'b110) begin
                n_fails++;
                $display("FAIL flush_dw_hold: busy=%b wr=%b rd=%b expected 1 1 0",
                         busy, write_L1_L2, read_L1_L2);
            end
        end
        finish_txn(0, ri, rd);
        n_checks++;
        if ({ri, rd} !== 2'b01 || busy !== 1'b0 || write_L1_L2 !== 1'b0) begin
            n_fails++;
            $display("FAIL flush_dw_done: ri=%b rd=%b busy=%b wr=%b", ri, rd, busy, write_L1_L2);
        end
        read_L1I_L2 = 1'b1;
        ready_L2_L1 = 1'b1;
        #1;
        n_checks++;
        if ({ready_L2_L1I, ready_L2_L1D} !== 2'b00) begin
            n_fails++;
            $display("FAIL idle_ready_ignored: ri=%b rd=%b expected 0 0", ready_L2_L1I, ready_L2_L1D);
        end
        @(negedge clk);
        ready_L2_L1 = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fails++;
            $display("FAIL idle_ready_state: busy=%b expected 0", busy);
        end
        read_L1I_L2 = 1'b0;
        flush = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit ok;
        logic ri, rd;
        push_exp(2'b10, 21'h06666, 5'h16, last_wdata);
        read_L1D_L2 = 1'b1; tag_L1D_L2 = 21'h06666; index_L1D_L2 = 5'h16;
        wait_busy(20, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL rmid_grant: timed out"); end
        #2;
        nrst = 1'b0;
        ready_L2_L1 = 1'b1;
        #1;
        n_checks++;
        if ({busy, grant_o, read_L1_L2, write_L1_L2, ready_L2_L1I, ready_L2_L1D} !== 7'b0 ||
            tag_L1_L2 !== 21'h0 || index_L1_L2 !== 5'h0 || write_data_L1_L2 !== 512'h0) begin
            n_fails++;
            $display("FAIL rmid_async: busy=%b grant=%b rd=%b rdyD=%b tag=%h",
                     busy, grant_o, read_L1_L2, ready_L2_L1D, tag_L1_L2);
        end
        @(negedge clk);
        ready_L2_L1 = 1'b0;
        last_wdata = '0;
        push_exp(2'b10, 21'h06666, 5'h16, last_wdata);
        nrst = 1'b1;
        @(negedge clk);
        wait_busy(20, ok);
        n_checks++;
        if (!ok) begin n_fails++; $display("FAIL rmid_regrant: timed out"); end
        read_L1D_L2 = 1'b0;
        finish_txn(1, ri, rd);
        n_checks++;
        if ({ri, rd} !== 2'b01) begin
            n_fails++;
            $display("FAIL rmid_ready: ri=%b rd=%b expected 0 1", ri, rd);
        end
    endtask

    initial begin
        nrst = 1'b0;
        read_L1I_L2 = 1'b0; tag_L1I_L2 = '0; index_L1I_L2 = '0;
        read_L1D_L2 = 1'b0; tag_L1D_L2 = '0; index_L1D_L2 = '0;
        write_L1D_L2 = 1'b0; write_tag_L1D_L2 = '0; write_index_L1D_L2 = '0;
        write_data_L1D_L2 = '0;
        flush = 1'b0;
        ready_L2_L1 = 1'b0;

        test_reset();
        test_all_three();
        test_round_robin();
        test_single_l1i();
        test_addr_hold();
        test_flush();
        test_reset_mid();

        repeat (2) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL sb_drain: %0d expected grants never seen, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
